// File: rtl/npu_ahb_ram_gen2.sv
// AHB-Lite byte-addressable RAM slave with configurable wait states and ERROR responses.
// Read data and handshake outputs are registered; a write commits on the edge ending its data phase.
module npu_ahb_ram_gen2 #(
  parameter int    AW        = 16,
  parameter int    DW        = 32,
  parameter int    MEM_BYTES = 1 << AW,
  parameter int    WS_N      = 0,
  parameter int    WS_S      = 0,
  parameter int    ERR_EN    = 1,
  parameter string FILENAME  = ""
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [DW-1:0] HRDATA,
  output logic          HRESP
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int BW = AW - LB;
  localparam int MI = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [2:0] SZMAX = 3'(LB);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  logic [7:0] mem [MEM_BYTES];

  state_t          state_q;
  logic [31:0]     cnt_q;
  logic            rdy_q, resp_q;
  logic [DW-1:0]   rdata_q;
  logic            dp_wr_q;
  logic [BW-1:0]   dp_beat_q;
  logic [NB-1:0]   dp_mask_q;
  logic            prv_vld_q;
  logic [BW-1:0]   prv_beat_q;

  // Contents survive HRESETn; only power-up fills them.
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[MI'(i)] = 8'h00;
  end

  // Address-phase decode
  logic          accept, illegal, seq;
  logic [BW-1:0] a_beat;
  logic [NB-1:0] a_mask;
  logic [2:0]    a_szc;
  logic [31:0]   sz_full, sz_clip, a_ws;
  logic [32:0]   a_end;

  always_comb begin
    accept  = HSEL & HREADY & HTRANS[1] & rdy_q;
    a_beat  = HADDR[AW-1:LB];
    a_szc   = (HSIZE > SZMAX) ? SZMAX : HSIZE;
    sz_full = 32'd1 << HSIZE;
    sz_clip = 32'd1 << a_szc;
    a_mask  = NB'(((32'd1 << sz_clip) - 32'd1) << HADDR[LB-1:0]);
    a_end   = 33'(HADDR) + 33'(sz_full);
    illegal = (ERR_EN != 0) &&
              ((HSIZE > SZMAX) ||
               ((32'(HADDR) & (sz_full - 32'd1)) != 32'd0) ||
               (a_end > 33'(MEM_BYTES)));
    // HTRANS=SEQ alone cannot make the first beat after reset sequential
    seq     = prv_vld_q && ((HTRANS == 2'b11) || (a_beat == prv_beat_q) ||
                            (a_beat == prv_beat_q + BW'(1)));
    a_ws    = seq ? 32'(WS_S) : 32'(WS_N);
  end

  // Beat read, merging a write whose data phase ends on this same edge
  logic [BW-1:0] rd_beat;
  logic [NB-1:0] rd_mask;
  logic [DW-1:0] rd_word;
  logic [AW-1:0] rd_idx;
  logic          rd_fwd;

  always_comb begin
    rd_beat = (state_q == S_WAIT) ? dp_beat_q : a_beat;
    rd_mask = (state_q == S_WAIT) ? dp_mask_q : a_mask;
    rd_word = '0;
    rd_idx  = '0;
    rd_fwd  = 1'b0;
    for (int l = 0; l < NB; l++) begin
      rd_idx = {rd_beat, LB'(l)};
      rd_fwd = (state_q != S_WAIT) && dp_wr_q && rdy_q &&
               (dp_beat_q == rd_beat) && dp_mask_q[l];
      if (rd_mask[l]) begin
        if (rd_fwd)
          rd_word[l*8 +: 8] = HWDATA[l*8 +: 8];
        else if (33'(rd_idx) < 33'(MEM_BYTES))
          rd_word[l*8 +: 8] = mem[MI'(rd_idx)];
      end
    end
  end

  logic [NB-1:0] wr_en;
  logic [MI-1:0] wr_idx [NB];
  logic [AW-1:0] wr_full;

  always_comb begin
    wr_full = '0;
    for (int l = 0; l < NB; l++) begin
      wr_full   = {dp_beat_q, LB'(l)};
      wr_idx[l] = MI'(wr_full);
      wr_en[l]  = dp_wr_q && rdy_q && dp_mask_q[l] && (33'(wr_full) < 33'(MEM_BYTES));
    end
  end

  always_ff @(posedge HCLK) begin
    for (int l = 0; l < NB; l++)
      if (wr_en[l]) mem[wr_idx[l]] <= HWDATA[l*8 +: 8];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rdy_q      <= 1'b1;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      dp_wr_q    <= 1'b0;
      dp_beat_q  <= '0;
      dp_mask_q  <= '0;
      prv_vld_q  <= 1'b0;
      prv_beat_q <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          cnt_q <= cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
            rdata_q <= dp_wr_q ? '0 : rd_word;
          end
        end
        S_ERR1: begin
          state_q <= S_ERR2;
          rdy_q   <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          // IDLE and ERR2 both take a new address phase
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
          resp_q  <= 1'b0;
          rdata_q <= '0;
          dp_wr_q <= 1'b0;
          if (accept) begin
            dp_beat_q <= a_beat;
            dp_mask_q <= a_mask;
            if (illegal) begin
              state_q <= S_ERR1;
              rdy_q   <= 1'b0;
              resp_q  <= 1'b1;
            end else begin
              prv_vld_q  <= 1'b1;
              prv_beat_q <= a_beat;
              dp_wr_q    <= HWRITE;
              if (a_ws == 32'd0) begin
                rdata_q <= HWRITE ? '0 : rd_word;
              end else begin
                state_q <= S_WAIT;
                cnt_q   <= a_ws;
                rdy_q   <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  assign HREADYOUT = rdy_q;
  assign HRESP     = resp_q;
  assign HRDATA    = rdata_q;

endmodule
